uart_tx_arbiter: RTL
====================

Name: uart_tx_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one UART transmitter (send/din/odd in, busy out) between NUM_REQ byte requesters.
- Captures the granted requester's byte and drives the transmitter's full send handshake: assert send, see busy rise, see busy fall, release send.
- Returns a one-cycle ack to the requester once its frame has left the line.
- Sits between the system's message sources (console, status reporter, etc.) and the single tx instance.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..8.
- IDX_W, 2, width of the grant index; must equal clogb2(NUM_REQ).
- TIMEOUT_CYCLES, 1024, cycles allowed in SEND for busy to rise. Used only with UART_TX_ARB_TIMEOUT_EN.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  per-requester request; held high until the matching ack.
- req_data  in  8*NUM_REQ  byte for requester i on bits [8i+7:8i]; sampled only in the grant cycle.
- odd  in  1  parity select passed to the transmitter; sampled in the grant cycle.
- ack  out  NUM_REQ  one-cycle pulse to the granted requester when its frame is complete.
- grant_valid  out  1  high from the grant cycle through the DONE cycle.
- grant_idx  out  IDX_W  index of the current or last granted requester.
- tx_send  out  1  to transmitter send.
- tx_din  out  8  to transmitter din; registered, stable while grant_valid=1.
- tx_odd  out  1  to transmitter odd; registered.
- tx_busy  in  1  from transmitter busy.
- timeout_err  out  1  sticky error flag; present only with UART_TX_ARB_TIMEOUT_EN.

Behaviour:
- Reset values: state=IDLE, ack=0, grant_valid=0, grant_idx=0, tx_send=0, tx_din=0, tx_odd=0, rr_ptr=NUM_REQ-1 (so requester 0 wins first), timeout_err=0.
- Reset mid-transfer drops tx_send immediately. The transmitter then finishes its current frame on its own. The arbiter, now in IDLE, must not issue the next send while tx_busy=1.
- States:
  - IDLE: tx_send=0. If any req bit is high and tx_busy=0, grant the first set req bit searching from rr_ptr+1 with wrap at NUM_REQ-1 to 0. In that same edge, register tx_din, tx_odd and grant_idx, set grant_valid=1, and go to SEND. With no requests, stay in IDLE.
  - SEND: tx_send=1. On tx_busy=1 go to XMIT; otherwise stay.
  - XMIT: tx_send=1 (held so the transmitter parks in its wait state). On tx_busy=0 go to DONE.
  - DONE: tx_send=0, ack[grant_idx]=1 for exactly this cycle, rr_ptr<=grant_idx, grant_valid<=0, then go to IDLE. The transmitter returns to idle on this same edge.
- Grant latency: 1 cycle from req to the SEND state. The earliest re-grant is the cycle after DONE.
- Back-to-back frames: minimum 3 controller cycles of overhead (IDLE, SEND, DONE) plus the transmitter frame time.
- Fairness: a requester holding req continuously after its ack yields to any other pending requester. With a single active requester it is re-granted every frame.
- A req deasserted before it is granted is simply not granted. A req deasserted after grant is ignored: the frame completes and ack still pulses.
- req and req_data are not registered before arbitration. Requesters drive them synchronously to clk.
- At most one ack bit is high in any cycle. ack never pulses outside DONE.

Optional Feature:
- Macro: UART_TX_ARB_TIMEOUT_EN.
- Defined:
  - A counter of clogb2(TIMEOUT_CYCLES) bits runs in SEND and clears on entry to SEND.
  - If TIMEOUT_CYCLES elapse with tx_busy=0, go to DONE, set timeout_err=1 (sticky until reset) and still pulse ack so the requester is not hung.
  - The timeout_err port exists.
- Not defined: no counter, no timeout_err port, and SEND waits indefinitely.

Test Plan:
1. Single request: req=4'b0001 with data 0x55 and odd=0 → tx_din=0x55 one cycle later, tx_send high until busy falls, ack=4'b0001 for one cycle, 11 bit periods on the line.
2. Simultaneous requests after reset: req=4'b1010 with bytes 0xA1 (req1) and 0xB3 (req3) → req1 is granted first, then req3. Acks arrive in order 4'b0010 then 4'b1000 with no overlap.
3. Round-robin with all requesters held: req=4'b1111 for 5 frames → grant order 0, 1, 2, 3, 0.
4. Withdraw: req2 pulses high for 1 cycle while a req0 frame is in XMIT → req2 is never granted and never acked.
5. Reset in XMIT: assert reset while tx_busy=1 and req0 is held → tx_send drops next cycle, ack=0, and the next grant occurs only after tx_busy=0.
6. With UART_TX_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16: tx_busy tied to 0 and req=4'b0100 → DONE after 16 SEND cycles, ack=4'b0100, timeout_err=1 and it stays set.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART transmitter between
// NUM_REQ byte requesters. The granted byte is captured, the transmitter's
// send/busy handshake is driven to completion, and the requester receives a
// one-cycle ack once its frame has left the line.
// Optional build macro: UART_TX_ARB_TIMEOUT_EN adds a SEND-state watchdog
// and the sticky timeout_err output.
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int IDX_W          = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic                 odd,
  output logic [NUM_REQ-1:0]   ack,
  output logic                 grant_valid,
  output logic [IDX_W-1:0]     grant_idx,
  output logic                 tx_send,
  output logic [7:0]           tx_din,
  output logic                 tx_odd,
  input  logic                 tx_busy
`ifdef UART_TX_ARB_TIMEOUT_EN
  ,
  output logic                 timeout_err
`endif
);

  // Reject parameter sets the grant index or watchdog cannot represent.
  if (NUM_REQ < 2 || NUM_REQ > 8 || IDX_W != $clog2(NUM_REQ) || TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("uart_tx_arbiter: illegal parameter combination");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_XMIT,
    S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]   grant_idx_q, grant_idx_d;
  logic               grant_valid_q, grant_valid_d;
  logic [7:0]         tx_din_q, tx_din_d;
  logic               tx_odd_q, tx_odd_d;

  logic               pick_found;
  logic [IDX_W-1:0]   pick_idx;
  logic [7:0]         pick_data;

`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  logic [CNT_W-1:0]   to_cnt_q, to_cnt_d;
  logic               timeout_err_q, timeout_err_d;
`endif

  // Round-robin pick: first set req bit after rr_ptr, wrapping to 0.
  // NOTE: combinational blocks use blocking '=', only always_ff uses '<='.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      if (!pick_found && req[IDX_W'((int'(rr_ptr_q) + off) % NUM_REQ)]) begin
        pick_found = 1'b1;
        pick_idx   = IDX_W'((int'(rr_ptr_q) + off) % NUM_REQ);
      end
    end
  end

  // Select the winner's byte from the flattened data bus.
  always_comb begin
    pick_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_idx == IDX_W'(i)) pick_data = req_data[8*i +: 8];
    end
  end

  // Next-state and handshake outputs of the grant sequencer.
  // NOTE: every signal gets its default first so no path can infer a latch.
  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    grant_idx_d   = grant_idx_q;
    grant_valid_d = grant_valid_q;
    tx_din_d      = tx_din_q;
    tx_odd_d      = tx_odd_q;
    tx_send       = 1'b0;
`ifdef UART_TX_ARB_TIMEOUT_EN
    to_cnt_d      = to_cnt_q;
    timeout_err_d = timeout_err_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        // A frame still draining after a reset blocks the next grant.
        if (pick_found && !tx_busy) begin
          grant_idx_d   = pick_idx;
          grant_valid_d = 1'b1;
          tx_din_d      = pick_data;
          tx_odd_d      = odd;
          state_d       = S_SEND;
`ifdef UART_TX_ARB_TIMEOUT_EN
          to_cnt_d      = '0;
`endif
        end
      end
      S_SEND: begin
        tx_send = 1'b1;
        if (tx_busy) begin
          state_d = S_XMIT;
`ifdef UART_TX_ARB_TIMEOUT_EN
        end else if (to_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          // Transmitter never answered: finish anyway so the requester is released.
          state_d       = S_DONE;
          timeout_err_d = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
`endif
        end
      end
      S_XMIT: begin
        // send stays high so the transmitter parks until we release it.
        tx_send = 1'b1;
        if (!tx_busy) state_d = S_DONE;
      end
      S_DONE: begin
        rr_ptr_d      = grant_idx_q;
        grant_valid_d = 1'b0;
        state_d       = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // One-hot ack to the granted requester, only during DONE.
  always_comb begin
    ack = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      ack[i] = (state_q == S_DONE) && (grant_idx_q == IDX_W'(i));
    end
  end

  // State and captured-transfer registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      rr_ptr_q      <= IDX_W'(NUM_REQ - 1);
      grant_idx_q   <= '0;
      grant_valid_q <= 1'b0;
      tx_din_q      <= '0;
      tx_odd_q      <= 1'b0;
`ifdef UART_TX_ARB_TIMEOUT_EN
      to_cnt_q      <= '0;
      timeout_err_q <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      grant_idx_q   <= grant_idx_d;
      grant_valid_q <= grant_valid_d;
      tx_din_q      <= tx_din_d;
      tx_odd_q      <= tx_odd_d;
`ifdef UART_TX_ARB_TIMEOUT_EN
      to_cnt_q      <= to_cnt_d;
      timeout_err_q <= timeout_err_d;
`endif
    end
  end

  assign grant_valid = grant_valid_q;
  assign grant_idx   = grant_idx_q;
  assign tx_din      = tx_din_q;
  assign tx_odd      = tx_odd_q;
`ifdef UART_TX_ARB_TIMEOUT_EN
  assign timeout_err = timeout_err_q;
`endif

endmodule
